// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth multiply-accumulate unit.
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = XLEN / 2 + 1;
  localparam int EXTW  = XLEN + 2;
  localparam int RESW  = 2 * XLEN;
  localparam int CNTW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_P1   = 3'd1,
    BD_P2   = 3'd2,
    BD_M1   = 3'd3,
    BD_M2   = 3'd4
  } bd_t;

  // Two extra bits keep the top Booth digit correct for unsigned operands.
  function automatic logic [EXTW-1:0] ext34(input logic [XLEN-1:0] v, input logic s);
    return {{2{s & v[XLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: three multiplier bits -> {neg, two, zero}.
module booth_enc
  import mul_pkg::*;
(
  input  logic [2:0] i_bits,
  output logic       o_neg,
  output logic       o_two,
  output logic       o_zero
);

  bd_t w_digit;

  // Map the overlapping bit triple onto a signed digit in {-2..+2}.
  always_comb begin
    w_digit = BD_ZERO;
    case (i_bits)
      3'b001, 3'b010: w_digit = BD_P1;
      3'b011:         w_digit = BD_P2;
      3'b100:         w_digit = BD_M2;
      3'b101, 3'b110: w_digit = BD_M1;
      default:        w_digit = BD_ZERO;
    endcase
  end

  assign o_zero = (w_digit == BD_ZERO);
  assign o_two  = (w_digit == BD_P2) || (w_digit == BD_M2);
  assign o_neg  = (w_digit == BD_M1) || (w_digit == BD_M2);

endmodule

// File: rtl/booth_mul32.sv
// Iterative radix-4 Booth multiply-accumulate: {hi,lo} = op1*op2 + acc.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a start pulse; o_result holds last answer
//   ST_RUN  | one Booth digit accumulated per cycle, cnt 0..ITERS-1
//   ST_DONE | single cycle with o_vld high; result already registered
module booth_mul32
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vld,
  input  logic            i_sign,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [RESW-1:0] i_acc,
  output logic            o_vld,
  output logic [RESW-1:0] o_result
);

  localparam logic [CNTW-1:0] LAST = CNTW'(ITERS - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [CNTW-1:0] r_cnt;
  logic [EXTW-1:0] r_m;
  logic [EXTW:0]   r_q;
  logic [RESW-1:0] r_p;
  logic [RESW-1:0] r_result;

  logic            w_neg;
  logic            w_two;
  logic            w_zero;
  logic [RESW-1:0] w_m64;
  logic [RESW-1:0] w_mag;
  logic [RESW-1:0] w_sh;
  logic [RESW-1:0] w_addend;
  logic [RESW-1:0] w_p_next;
  logic            w_last;

  booth_enc u_enc (
    .i_bits (r_q[2:0]),
    .o_neg  (w_neg),
    .o_two  (w_two),
    .o_zero (w_zero)
  );

  assign w_m64    = {{(RESW-EXTW){r_m[EXTW-1]}}, r_m};
  assign w_mag    = w_zero ? '0 : (w_two ? (w_m64 << 1) : w_m64);
  assign w_sh     = w_mag << {r_cnt, 1'b0};
  // Negative digits use the inverted partial product plus a carry-in.
  assign w_addend = w_neg ? ~w_sh : w_sh;
  assign w_p_next = r_p + w_addend + {{(RESW-1){1'b0}}, w_neg};
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a start pulse always (re)enters RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_vld) w_state_next = ST_RUN;
      ST_RUN: begin
        if (i_vld)       w_state_next = ST_RUN;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = i_vld ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand load on start, otherwise one Booth iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_q   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (i_vld) begin
      r_m   <= ext34(i_op1, i_sign);
      r_q   <= {ext34(i_op2, i_sign), 1'b0};
      r_p   <= i_acc;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_p   <= w_p_next;
      r_q   <= {{2{r_q[EXTW]}}, r_q[EXTW:2]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the finished sum on the last iteration; aborts leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_result <= '0;
    else if (w_last && !i_vld)  r_result <= w_p_next;
  end

  assign o_vld    = (r_state == ST_DONE);
  assign o_result = r_result;

endmodule
